// File: rtl/can_pkg.sv
// Shared CAN definitions: CRC-15 polynomial/width, bit-counter width and the
// CRC sequencer FSM state type.
package can_pkg;

    localparam int unsigned CRC15_W = 15;
    localparam logic [CRC15_W-1:0] CRC15_POLY = 15'h4599;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CRC_LAST_IDX = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRC     = 2'd2,
        ST_DELIM   = 2'd3
    } can_state_e;

endpackage

// File: rtl/can_crc15_lfsr.sv
// CAN CRC-15 generator: MSB-first Galois LFSR, polynomial CRC15_POLY, init 0.
// Ports:
//   clk, rst_n : clock, async active-low reset (crc -> 0)
//   clear      : synchronous clear to 0 (priority over enable)
//   enable     : consume din this cycle
//   din        : serial input bit
//   crc        : current CRC register
module can_crc15_lfsr
    import can_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic               din,
    output logic [CRC15_W-1:0] crc
);

    logic fb;

    assign fb = din ^ crc[CRC15_W-1];

    // Shift left, fold polynomial in when feedback is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[CRC15_W-2:0], 1'b0} ^ (fb ? CRC15_POLY : CRC15_W'(0));
        end
    end

endmodule

// File: rtl/can_crc_seq.sv
// CAN CRC sequencer: passes the destuffed payload to tx_bit while accumulating
// CRC-15, then shifts the CRC out MSB first, then drives the recessive CRC
// delimiter and pulses done. All sequencing advances on bit_tick only; abort
// returns to IDLE at once and keeps the CRC for inspection.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   bit_tick          : one-clk pulse per CAN bit time
//   frame_start       : start a frame (accepted only in IDLE)
//   abort             : level, terminates the frame (wins over frame_start)
//   in_bit, in_last   : payload bit and last-CRC-covered-bit qualifier
//   in_ready          : high in PAYLOAD
//   tx_bit            : registered transmit bit, recessive 1 when idle
//   crc_out           : current CRC register
//   busy, done        : not-IDLE flag, one-clk pulse on delimiter exit
// Optional macro CAN_CRC_SEQ_RX_CHECK_EN adds:
//   rx_bit            : sampled bus bit, compared against each sent CRC bit
//   crc_err           : sticky mismatch flag, cleared by accepted frame_start
module can_crc_seq
    import can_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_tick,
    input  logic               frame_start,
    input  logic               abort,
    input  logic               in_bit,
    input  logic               in_last,
    output logic               in_ready,
    output logic               tx_bit,
    output logic [CRC15_W-1:0] crc_out,
    output logic               busy,
    output logic               done
`ifdef CAN_CRC_SEQ_RX_CHECK_EN
    ,
    input  logic               rx_bit,
    output logic               crc_err
`endif
);

    can_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] crc_idx;
    logic             tx_nxt;
    logic             done_nxt;
    logic             crc_clr;
    logic             crc_en;
    logic             crc_bit;
`ifdef CAN_CRC_SEQ_RX_CHECK_EN
    logic             err_nxt;
`endif

    // CRC bits go out MSB first: index 14 down to 0
    assign crc_idx = CRC_LAST_IDX - cnt;
    assign crc_bit = crc_out[crc_idx];

    can_crc15_lfsr u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (crc_clr),
        .enable (crc_en),
        .din    (in_bit),
        .crc    (crc_out)
    );

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tx_bit   <= 1'b1;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tx_bit   <= tx_nxt;
            done     <= done_nxt;
            busy     <= (state_nxt != ST_IDLE);
            in_ready <= (state_nxt == ST_PAYLOAD);
        end
    end

`ifdef CAN_CRC_SEQ_RX_CHECK_EN
    // Sticky CRC readback error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_err <= 1'b0;
        end else begin
            crc_err <= err_nxt;
        end
    end
`endif

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tx_nxt    = tx_bit;
        done_nxt  = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
`ifdef CAN_CRC_SEQ_RX_CHECK_EN
        err_nxt   = crc_err;
`endif
        if (abort) begin
            // CRC register is left untouched for debug
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            tx_nxt    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_nxt = 1'b1;
                    if (frame_start) begin
                        state_nxt = ST_PAYLOAD;
                        cnt_nxt   = '0;
                        crc_clr   = 1'b1;
`ifdef CAN_CRC_SEQ_RX_CHECK_EN
                        err_nxt   = 1'b0;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    if (bit_tick) begin
                        crc_en = 1'b1;
                        tx_nxt = in_bit;
                        if (in_last) begin
                            state_nxt = ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    if (bit_tick) begin
                        tx_nxt = crc_bit;
`ifdef CAN_CRC_SEQ_RX_CHECK_EN
                        if (rx_bit != crc_bit) begin
                            err_nxt = 1'b1;
                        end
`endif
                        if (cnt == CRC_LAST_IDX) begin
                            state_nxt = ST_DELIM;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DELIM: begin
                    if (bit_tick) begin
                        tx_nxt    = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    tx_nxt    = 1'b1;
                end
            endcase
        end
    end

endmodule
